key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/key_conditioner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// key_pkg: direction codes, per-key FSM state type and the pending-flag priority helper.
package key_pkg;

  localparam int NUM_KEYS = 4;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  // Lowest set bit wins, which gives left > right > up > down.
  function automatic logic [1:0] prio_dir(input logic [NUM_KEYS-1:0] pend);
    prio_dir = DIR_DOWN;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) prio_dir = 2'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// key_debounce: 2-flop synchronizer and stability counter for one active-low push-button.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Inverted ahead of the synchronizer so a cleared flop means "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= ~i_key_n;
      r_sync <= r_meta;
      // The counter measures how long the synchronized level has disagreed with the accepted level.
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// key_conditioner: debounces four direction keys, generates press/auto-repeat events and
// queues them as single-entry pending flags behind a valid/ready move interface.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_key_n,
  output logic [3:0] o_key_level,
  output logic       o_move_valid,
  output logic [1:0] o_move_dir,
  input  logic       i_move_ready,
  output logic       o_event_dropped
);

  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_event;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_t    r_state;
    key_state_t    w_state_next;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_next;
    logic          w_evt;

    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .i_key_n(i_key_n[k]),
      .o_level(w_level[k])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_next;
        r_rcnt  <= w_rcnt_next;
      end
    end

    // A release always wins over a repeat that would fall due in the same cycle.
    always_comb begin
      w_state_next = r_state;
      w_rcnt_next  = r_rcnt;
      case (r_state)
        ST_IDLE: begin
          if (w_level[k]) begin
            w_state_next = ST_HELD;
            w_rcnt_next  = '0;
          end
        end
        ST_HELD: begin
          if (!w_level[k]) begin
            w_state_next = ST_IDLE;
            w_rcnt_next  = '0;
          end else if (r_rcnt == DELAY_LAST) begin
            w_state_next = ST_REPEAT;
            w_rcnt_next  = '0;
          end else if (r_rcnt < DELAY_LAST) begin
            w_rcnt_next = r_rcnt + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_level[k]) begin
            w_state_next = ST_IDLE;
            w_rcnt_next  = '0;
          end else if (r_rcnt == RATE_LAST) begin
            w_rcnt_next = '0;
          end else if (r_rcnt < RATE_LAST) begin
            w_rcnt_next = r_rcnt + RW'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_rcnt_next  = '0;
        end
      endcase
    end

    always_comb begin
      w_evt = 1'b0;
      case (r_state)
        ST_IDLE:   w_evt = w_level[k];
        ST_HELD:   w_evt = w_level[k] && (r_rcnt == DELAY_LAST);
        ST_REPEAT: w_evt = w_level[k] && (r_rcnt == RATE_LAST);
        default:   w_evt = 1'b0;
      endcase
    end

    assign w_event[k] = w_evt;
  end

  logic [NUM_KEYS-1:0] r_pend;
  logic                r_valid;
  logic [1:0]          r_dir;
  logic                w_load;
  logic [1:0]          w_sel;
  logic [NUM_KEYS-1:0] w_clr;
  logic [NUM_KEYS-1:0] w_pend_next;

  // The output slot refills on the same edge it drains; a new event beats its own clear.
  always_comb begin
    w_load          = (!r_valid || i_move_ready) && (|r_pend);
    w_sel           = prio_dir(r_pend);
    w_clr           = w_load ? (NUM_KEYS'(1) << w_sel) : '0;
    w_pend_next     = w_event | (r_pend & ~w_clr);
    o_event_dropped = |(w_event & r_pend & ~w_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_dir   <= DIR_LEFT;
    end else begin
      r_pend <= w_pend_next;
      if (w_load) begin
        r_valid <= 1'b1;
        r_dir   <= w_sel;
      end else if (i_move_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_key_level  = w_level;
  assign o_move_valid = r_valid;
  assign o_move_dir   = r_dir;

endmodule
`default_nettype wire
